muldiv_ctrl: RTL

Sequencer for the execute stage's multi-cycle units: one fixed-latency pipelined multiplier and one iterative divider, both instantiated beside it in Execute. It accepts the mul/div instruction held in the execute register and launches exactly one unit. It raises `eu_stall` until the result is captured, then holds the result while downstream is not ready. On flush it cancels in-flight work.

---
 rtl/cpu_defs.sv | 28 ++
 rtl/muldiv_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: mul/div operation encoding used by Execute.
`timescale 1ns/1ps

package cpu_defs;

  // One 2-bit code serves both units: MUL uses LO/HI/HIU, DIV uses Q/R/QU/RU.
  typedef enum logic [1:0] {
    MdLoQ   = 2'd0,
    MdHiR   = 2'd1,
    MdHiuQu = 2'd2,
    MdRu    = 2'd3
  } md_op_t;

  localparam logic [31:0] DivZeroQuot = 32'hFFFF_FFFF;

  function automatic logic md_is_signed(input md_op_t op);
    return ~op[1];
  endfunction

  function automatic logic md_mul_hi(input md_op_t op);
    return op != MdLoQ;
  endfunction

  function automatic logic md_div_rem(input md_op_t op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Execute-stage sequencer for the pipelined multiplier and the iterative divider:
// launches one unit, stalls execute until the result is captured, holds it for Memory1.
`timescale 1ns/1ps

module muldiv_ctrl
  import cpu_defs::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_is_div,
  input  md_op_t      req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  input  logic        next_rdy,
  output logic        mul_start,
  output logic        mul_signed,
  input  logic [63:0] mul_prod,
  output logic        div_start,
  output logic        div_signed,
  input  logic        div_done,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic        unit_cancel,
  output logic        eu_stall,
  output logic        res_valid,
  output logic [31:0] res
);

  localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StMulWait, StDivWait, StDone} state_e;

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  md_op_t          r_op, w_op_nxt, w_op;
  logic [31:0]     r_res, w_res_nxt;
  logic            r_res_valid, w_res_valid_nxt;
  logic            w_launch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_op        <= MdLoQ;
      r_res       <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_op        <= w_op_nxt;
      r_res       <= w_res_nxt;
      r_res_valid <= w_res_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_op_nxt        = r_op;
    w_res_nxt       = r_res;
    w_res_valid_nxt = r_res_valid;
    unique case (r_state)
      StIdle: begin
        if (req_valid && !flush) begin
          w_op_nxt = req_op;
          if (!req_is_div) begin
            w_cnt_nxt   = CntW'(MUL_LAT - 1);
            w_state_nxt = StMulWait;
          end else if (req_b == '0) begin
            // Divide-by-zero never reaches the divider; the result is architecturally fixed.
            w_res_nxt       = md_div_rem(req_op) ? req_a : DivZeroQuot;
            w_res_valid_nxt = 1'b1;
            w_state_nxt     = StDone;
          end else begin
            w_state_nxt = StDivWait;
          end
        end
      end
      StMulWait: begin
        if (flush) begin
          w_cnt_nxt   = '0;
          w_state_nxt = StIdle;
        end else if (r_cnt == '0) begin
          w_res_nxt       = md_mul_hi(r_op) ? mul_prod[63:32] : mul_prod[31:0];
          w_res_valid_nxt = 1'b1;
          w_state_nxt     = StDone;
        end else begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end
      end
      StDivWait: begin
        if (flush) begin
          w_state_nxt = StIdle;
        end else if (div_done) begin
          w_res_nxt       = md_div_rem(r_op) ? div_r : div_q;
          w_res_valid_nxt = 1'b1;
          w_state_nxt     = StDone;
        end
      end
      StDone: begin
        if (flush || next_rdy) begin
          w_res_valid_nxt = 1'b0;
          w_state_nxt     = StIdle;
        end
      end
      default: begin
        w_res_valid_nxt = 1'b0;
        w_state_nxt     = StIdle;
      end
    endcase
  end

  always_comb begin
    // In IDLE the op is not latched yet, so signedness follows the request for the launch pulse.
    w_op        = (r_state == StIdle) ? req_op : r_op;
    w_launch    = !rst && (r_state == StIdle) && req_valid && !flush;
    mul_start   = w_launch && !req_is_div;
    div_start   = w_launch && req_is_div && (req_b != '0);
    mul_signed  = md_is_signed(w_op);
    div_signed  = md_is_signed(w_op);
    unit_cancel = !rst && flush && (r_state != StIdle);
    eu_stall    = !rst && req_valid && !flush && (r_state != StDone);
  end

  assign res       = r_res;
  assign res_valid = r_res_valid;

endmodule
